// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for an 8:1 single-bit mux.
// Streams the granted requester's bit over valid/ready, bounded by HOLD_MAX beats.
module mux_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] a,
    input  logic       ready,
    output logic [2:0] select,
    output logic [7:0] grant,
    output logic       valid,
    output logic       y,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    logic [2:0] last;
    logic [7:0] beat_cnt;

    logic [2:0] winner;
    logic [2:0] idx;
    logic       found;
    logic       accept;
    logic [7:0] cnt_nxt;
    logic       hold_hit;

    // First requester after last, wrapping; last itself is tried last.
    always_comb begin
        winner = last;
        idx    = '0;
        found  = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = last + 3'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign busy     = (state == GRANT);
    assign valid    = busy & req[select];
    assign y        = valid & a[select];
    assign accept   = valid & ready;
    assign cnt_nxt  = beat_cnt + 8'd1;
    assign hold_hit = (cnt_nxt == 8'(HOLD_MAX));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            select   <= '0;
            grant    <= '0;
            last     <= 3'd7;
            beat_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        select   <= winner;
                        grant    <= 8'(1) << winner;
                        last     <= winner;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req[select]) begin
                        state <= IDLE;
                        grant <= '0;
                    end else if (accept) begin
                        beat_cnt <= cnt_nxt;
                        if (hold_hit) begin
                            state <= IDLE;
                            grant <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
